display_scroll_ctrl: RTL

//   Scheduler for the 2-bit character decoders (U / 7 / 2 / 3 alphabet) on HEX0..HEX3.

---
 rtl/display_scroll_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/display_scroll_ctrl.sv
// display_scroll_ctrl
//   Drives four 2-bit character decoders on HEX0..HEX3. The decoders use the
//   U / 7 / 2 / 3 alphabet. A short message is entered from the switches, one
//   character per LOAD strobe. The message is then scrolled across the digits,
//   advancing one position every TICK_DIV clocks. All outputs are registered,
//   so they show the state from the previous cycle.
//
//   Optional feature: define SCROLL_DIR_EN to add the DIR input. With DIR = 1
//   the message scrolls the other way.
//
// Ports
//   CLOCK_50  in   system clock, rising edge
//   RESET     in   synchronous, active-high reset
//   SW_CODE   in   2-bit character to append (00 U, 01 7, 10 2, 11 3)
//   LOAD      in   strobe: append SW_CODE (IDLE only, ignored when full)
//   START     in   strobe: start scrolling from IDLE, or resume from HOLD
//   STOP      in   strobe: freeze scrolling (RUN -> HOLD)
//   CLEAR     in   strobe: empty the message and return to IDLE
//   DIR       in   scroll direction, 1 = decrement (only with SCROLL_DIR_EN)
//   C_OUT     out  digit k code at [2k+1:2k], digit 0 = HEX0 (rightmost)
//   BLANK     out  1 = digit k dark
//   BUSY      out  1 while scrolling
//   FULL      out  1 when the message buffer holds MSG_LEN characters
module display_scroll_ctrl #(
    parameter int unsigned TICK_DIV   = 25_000_000,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned MSG_LEN    = 8
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET,
    input  logic [1:0]              SW_CODE,
    input  logic                    LOAD,
    input  logic                    START,
    input  logic                    STOP,
    input  logic                    CLEAR,
`ifdef SCROLL_DIR_EN
    input  logic                    DIR,
`endif
    output logic [2*NUM_DIGITS-1:0] C_OUT,
    output logic [NUM_DIGITS-1:0]   BLANK,
    output logic                    BUSY,
    output logic                    FULL
);

    localparam int unsigned CW = $clog2(MSG_LEN + 1);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    // Wide enough for offset + digit index before the wrap subtract.
    localparam int unsigned IW = $clog2(MSG_LEN + NUM_DIGITS) + 1;

    localparam logic [CW-1:0] MsgLenC  = CW'(MSG_LEN);
    localparam logic [PW-1:0] TickLast = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

    state_e        r_state, w_state_d;
    logic [CW-1:0] r_count, w_count_d;
    logic [CW-1:0] r_wr_ptr, w_wr_ptr_d;
    logic [CW-1:0] r_offset, w_offset_d;
    logic [PW-1:0] r_presc, w_presc_d;
    logic [1:0]    r_msg [MSG_LEN];
    logic          w_msg_we;

    logic [2*NUM_DIGITS-1:0] r_c_out, w_c_out;
    logic [NUM_DIGITS-1:0]   r_blank, w_blank;
    logic                    r_busy, r_full;

    logic          w_full;
    logic          w_dir;
    logic [CW-1:0] w_offset_inc, w_offset_dec, w_offset_step;

    assign w_full = (r_count == MsgLenC);

`ifdef SCROLL_DIR_EN
    assign w_dir = DIR;
`else
    assign w_dir = 1'b0;
`endif

    // Modulo-count stepping without a divider: offset is always < count.
    assign w_offset_inc  = (r_offset + CW'(1) == r_count) ? '0 : r_offset + CW'(1);
    assign w_offset_dec  = (r_offset == '0) ? r_count - CW'(1) : r_offset - CW'(1);
    assign w_offset_step = w_dir ? w_offset_dec : w_offset_inc;

    // Next-state logic. Priority is CLEAR > STOP > START > LOAD.
    always_comb begin
        w_state_d  = r_state;
        w_count_d  = r_count;
        w_wr_ptr_d = r_wr_ptr;
        w_offset_d = r_offset;
        w_presc_d  = r_presc;
        w_msg_we   = 1'b0;

        if (CLEAR) begin
            w_state_d  = StIdle;
            w_count_d  = '0;
            w_wr_ptr_d = '0;
            w_offset_d = '0;
            w_presc_d  = '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (!STOP) begin
                        if (START && (r_count != '0)) begin
                            w_state_d  = StRun;
                            w_offset_d = '0;
                            w_presc_d  = '0;
                        end else if (LOAD && !w_full) begin
                            w_msg_we   = 1'b1;
                            w_wr_ptr_d = r_wr_ptr + CW'(1);
                            w_count_d  = r_count + CW'(1);
                        end
                    end
                end
                StRun: begin
                    if (STOP) begin
                        w_state_d = StHold;
                    end else if (r_presc == TickLast) begin
                        w_presc_d  = '0;
                        w_offset_d = w_offset_step;
                    end else begin
                        w_presc_d = r_presc + PW'(1);
                    end
                end
                StHold: begin
                    // Prescaler is left as is, so the current step resumes part-way.
                    if (!STOP && START) begin
                        w_state_d = StRun;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    // Display mapping: digit k shows msg[(offset + k) mod count]. The sum is
    // below 2*count, so a single compare/subtract wraps it.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        logic [IW-1:0] w_sum;
        logic [AW-1:0] w_idx;
        logic          w_show;

        assign w_sum  = IW'(r_offset) + IW'(g);
        assign w_idx  = AW'((w_sum >= IW'(r_count)) ? w_sum - IW'(r_count) : w_sum);
        assign w_show = (IW'(g) < IW'(r_count));

        assign w_c_out[2*g +: 2] = w_show ? r_msg[w_idx] : 2'b00;
        assign w_blank[g]        = ~w_show;
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state  <= StIdle;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_offset <= '0;
            r_presc  <= '0;
            r_c_out  <= '0;
            r_blank  <= '1;
            r_busy   <= 1'b0;
            r_full   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_count  <= w_count_d;
            r_wr_ptr <= w_wr_ptr_d;
            r_offset <= w_offset_d;
            r_presc  <= w_presc_d;
            r_c_out  <= w_c_out;
            r_blank  <= w_blank;
            r_busy   <= (r_state == StRun);
            r_full   <= w_full;
        end
    end

    // The buffer is not reset: count = 0 hides any stale characters.
    always_ff @(posedge CLOCK_50) begin
        if (w_msg_we) begin
            r_msg[r_wr_ptr[AW-1:0]] <= SW_CODE;
        end
    end

    assign C_OUT = r_c_out;
    assign BLANK = r_blank;
    assign BUSY  = r_busy;
    assign FULL  = r_full;

endmodule
